pm_fetch_reader: RTL and testbench



---
 rtl/pm_fetch_pkg.sv | 19 +
 rtl/pm_wait_timer.sv | 45 ++++
 rtl/pm_fetch_reader.sv | 115 +++++++++++
 tb/tb_pm_fetch_reader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pm_fetch_pkg.sv
// Shared types, limits and helpers for the slow program-memory fetch reader.
package pm_fetch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

    localparam int TIMER_W         = 4;
    localparam int WAIT_CYCLES_MIN = 1;
    localparam int WAIT_CYCLES_MAX = (1 << TIMER_W) - 1;
    localparam int CNT_W           = 8;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/pm_wait_timer.sv
// Loadable down-counter that flags the cycle in which a loaded count has run out.
module pm_wait_timer
    import pm_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    input  logic               clear_i,
    output logic               done_o
);

    logic [TIMER_W-1:0] count_q, count_d;
    logic               running_q, running_d;

    assign done_o = running_q && (count_q == '0);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        count_d   = count_q;
        running_d = running_q;
        if (clear_i) begin
            count_d   = '0;
            running_d = 1'b0;
        end else if (load_i) begin
            count_d   = load_val_i;
            running_d = 1'b1;
        end else if (done_o) begin
            running_d = 1'b0;
        end else if (running_q) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            running_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            running_q <= running_d;
        end
    end

endmodule

// File: rtl/pm_fetch_reader.sv
// CPU-side reader for the slow program ROM: wait-state miss path, one-entry
// last-fetch buffer for repeated addresses, and saturating hit/miss statistics.
module pm_fetch_reader
    import pm_fetch_pkg::*;
#(
    parameter int WAIT_CYCLES = 3,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              flush,
    output logic [ADDR_W-1:0] pm_addr,
    input  logic [DATA_W-1:0] pm_data,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    output logic              busy,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    if (WAIT_CYCLES < WAIT_CYCLES_MIN || WAIT_CYCLES > WAIT_CYCLES_MAX) begin : g_bad_wait
        $error("pm_fetch_reader: WAIT_CYCLES must lie in 1..15");
    end

    // The timer counts the settle cycles remaining after the launch edge.
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(WAIT_CYCLES - 1);

    fetch_state_t      state_q;
    logic [ADDR_W-1:0] pm_addr_q, tag_q;
    logic [DATA_W-1:0] instr_q, buf_q;
    logic              tag_valid_q, valid_q, busy_q;
    logic [CNT_W-1:0]  hit_cnt_q, miss_cnt_q, hit_cnt_d, miss_cnt_d;

    logic accept, hit, launch, abort, timer_done;

    assign accept     = (state_q == IDLE) && fetch_req && !flush;
    assign hit        = tag_valid_q && (fetch_addr == tag_q);
    assign launch     = accept && !hit;
    assign abort      = (state_q == WAIT) && flush;
    assign hit_cnt_d  = sat_inc(hit_cnt_q);
    assign miss_cnt_d = sat_inc(miss_cnt_q);

    pm_wait_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (launch),
        .load_val_i (TIMER_LOAD),
        .clear_i    (abort),
        .done_o     (timer_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pm_addr_q   <= '0;
            instr_q     <= '0;
            // NOTE: the buffer is a plain register, so it is reset along with its tag.
            buf_q       <= '0;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking default makes instr_valid a one-cycle pulse unless re-set below.
            valid_q <= 1'b0;
            if (flush) begin
                tag_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            instr_q   <= buf_q;
                            valid_q   <= 1'b1;
                            hit_cnt_q <= hit_cnt_d;
                        end else begin
                            pm_addr_q  <= fetch_addr;
                            miss_cnt_q <= miss_cnt_d;
                            busy_q     <= 1'b1;
                            state_q    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // An abort drops the fetch silently; instr_out and pm_addr keep their values.
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (timer_done) begin
                        instr_q     <= pm_data;
                        buf_q       <= pm_data;
                        tag_q       <= pm_addr_q;
                        tag_valid_q <= 1'b1;
                        valid_q     <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
            endcase
        end
    end

    assign pm_addr     = pm_addr_q;
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign busy        = busy_q;
    assign hit_count   = hit_cnt_q;
    assign miss_count  = miss_cnt_q;

endmodule

// File: tb/tb_pm_fetch_reader.sv
// Bench for pm_fetch_reader: three instances (WAIT_CYCLES 3, 1, 15) share one clock and reset.
module tb_pm_fetch_reader;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] addr;
        bit         hit;
        logic [7:0] data;
    } vec_t;

    function automatic int wait_of(input int i);
        return (i == 0) ? 3 : ((i == 1) ? 1 : 15);
    endfunction

    function automatic logic [7:0] rom(input logic [7:0] a);
        return a ^ 8'hB5;
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    logic       clk = 1'b0;
    logic       reset;
    logic       req_a     [3];
    logic [7:0] addr_a    [3];
    logic       flush_a   [3];
    logic [7:0] pm_addr_a [3];
    logic [7:0] pm_data_a [3];
    logic [7:0] out_a     [3];
    logic       valid_a   [3];
    logic       busy_a    [3];
    logic [7:0] hit_a     [3];
    logic [7:0] miss_a    [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pm_fetch_reader #(
            .WAIT_CYCLES (wait_of(g)),
            .ADDR_W      (8),
            .DATA_W      (8)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .fetch_req   (req_a[g]),
            .fetch_addr  (addr_a[g]),
            .flush       (flush_a[g]),
            .pm_addr     (pm_addr_a[g]),
            .pm_data     (pm_data_a[g]),
            .instr_out   (out_a[g]),
            .instr_valid (valid_a[g]),
            .busy        (busy_a[g]),
            .hit_count   (hit_a[g]),
            .miss_count  (miss_a[g])
        );
        if (g == 0) begin : g_slow_rom
            // Data settles two clocks after the address changes; stale data shows meanwhile.
            logic [7:0] d1, d2;
            always @(posedge clk) begin
                d1 <= rom(pm_addr_a[g]);
                d2 <= d1;
            end
            assign pm_data_a[g] = d2;
        end else begin : g_fast_rom
            assign pm_data_a[g] = rom(pm_addr_a[g]);
        end
    end

    int         pass_n = 0;
    int         total_n = 0;
    exp_t       exp_q[$];
    int         exp_hit_n  [3];
    int         exp_miss_n [3];
    logic [7:0] exp_pm     [3];
    logic [7:0] last_data  [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard: every instr_valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (valid_a[i] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", valid_a[i], 1'b0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("instr_out", out_a[i], e.data);
                end
            end
        end
    end

    // Starts just after a negedge; returns at the negedge where instr_valid is seen.
    // Expected negedges until valid: 1 for a hit, WAIT_CYCLES+1 for a miss
    // (capture at edge k+WAIT_CYCLES, valid sampled on the following negedge).
    task automatic do_fetch(input int idx, input logic [7:0] addr, input bit exp_hit,
                            input logic [7:0] exp_data, input bit swap, input logic [7:0] alt);
        int n;
        bit got;
        req_a[idx]  = 1'b1;
        addr_a[idx] = addr;
        exp_q.push_back('{idx, exp_data});
        if (exp_hit) exp_hit_n[idx]++;
        else begin
            exp_miss_n[idx]++;
            exp_pm[idx] = addr;
        end
        last_data[idx] = exp_data;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("busy_after_accept", busy_a[idx], !exp_hit);
                if (swap) addr_a[idx] = alt;
            end
            if (valid_a[idx] === 1'b1) got = 1'b1;
        end
        check("fetch_latency", n, exp_hit ? 1 : wait_of(idx) + 1);
        check("pm_addr", pm_addr_a[idx], exp_pm[idx]);
        check("hit_count", hit_a[idx], sat(exp_hit_n[idx]));
        check("miss_count", miss_a[idx], sat(exp_miss_n[idx]));
    endtask

    task automatic idle_cycles(input int idx, input int cycles, output bit seen);
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (valid_a[idx] !== 1'b0) seen = 1'b1;
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 3; i++) begin
            exp_hit_n[i]  = 0;
            exp_miss_n[i] = 0;
            exp_pm[i]     = 8'h00;
            last_data[i]  = 8'h00;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        bit   seen;
        vecs = '{'{8'h10, 1'b0, 8'hA5}, '{8'h10, 1'b1, 8'hA5},
                 '{8'h10, 1'b1, 8'hA5}, '{8'h11, 1'b0, 8'hA4},
                 '{8'h11, 1'b1, 8'hA4}, '{8'h10, 1'b0, 8'hA5},
                 '{8'hFF, 1'b0, 8'h4A}, '{8'hFF, 1'b1, 8'h4A}};
        reset_model();
        for (int i = 0; i < 3; i++) begin
            req_a[i]   = 1'b0;
            addr_a[i]  = 8'h00;
            flush_a[i] = 1'b0;
        end
        reset = 1'b1;
        #1;
        check("rst_pm_addr", pm_addr_a[0], 8'h00);
        check("rst_instr_out", out_a[0], 8'h00);
        check("rst_valid", valid_a[0], 1'b0);
        check("rst_busy", busy_a[0], 1'b0);
        check("rst_hit_count", hit_a[0], 8'h00);
        check("rst_miss_count", miss_a[0], 8'h00);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Table: back-to-back misses and hits, tag replacement.
        for (int v = 0; v < 8; v++) begin
            do_fetch(0, vecs[v].addr, vecs[v].hit, vecs[v].data, 1'b0, 8'h00);
        end

        // Address change while busy is ignored.
        do_fetch(0, 8'h11, 1'b0, rom(8'h11), 1'b1, 8'h30);

        // Flush one cycle after accepting 0x20 aborts silently.
        req_a[0]  = 1'b1;
        addr_a[0] = 8'h20;
        exp_miss_n[0]++;
        exp_pm[0] = 8'h20;
        @(negedge clk);
        check("flush_busy_before", busy_a[0], 1'b1);
        req_a[0]   = 1'b0;
        flush_a[0] = 1'b1;
        @(negedge clk);
        flush_a[0] = 1'b0;
        check("flush_busy_after", busy_a[0], 1'b0);
        check("flush_valid", valid_a[0], 1'b0);
        idle_cycles(0, wait_of(0) + 2, seen);
        check("flush_no_valid", seen, 1'b0);
        check("flush_instr_hold", out_a[0], last_data[0]);
        check("flush_pm_addr_hold", pm_addr_a[0], 8'h20);
        check("flush_miss_count", miss_a[0], sat(exp_miss_n[0]));

        // Tag was cleared by the flush, so the old address misses again.
        do_fetch(0, 8'h11, 1'b0, rom(8'h11), 1'b0, 8'h00);

        // Flush in IDLE blocks the request and clears the tag.
        req_a[0]   = 1'b1;
        addr_a[0]  = 8'h11;
        flush_a[0] = 1'b1;
        @(negedge clk);
        flush_a[0] = 1'b0;
        check("idle_flush_valid", valid_a[0], 1'b0);
        check("idle_flush_busy", busy_a[0], 1'b0);
        check("idle_flush_hits", hit_a[0], sat(exp_hit_n[0]));
        check("idle_flush_misses", miss_a[0], sat(exp_miss_n[0]));
        do_fetch(0, 8'h11, 1'b0, rom(8'h11), 1'b0, 8'h00);

        // Hit counter saturation.
        for (int h = 0; h < 300; h++) begin
            do_fetch(0, 8'h11, 1'b1, rom(8'h11), 1'b0, 8'h00);
        end
        check("hit_saturated", hit_a[0], 8'hFF);

        // Asynchronous reset in the middle of a miss.
        req_a[0]  = 1'b1;
        addr_a[0] = 8'h40;
        @(negedge clk);
        check("rst_mid_busy", busy_a[0], 1'b1);
        req_a[0] = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_mid_pm_addr", pm_addr_a[0], 8'h00);
        check("rst_mid_instr_out", out_a[0], 8'h00);
        check("rst_mid_valid", valid_a[0], 1'b0);
        check("rst_mid_busy_low", busy_a[0], 1'b0);
        check("rst_mid_hit_count", hit_a[0], 8'h00);
        check("rst_mid_miss_count", miss_a[0], 8'h00);
        @(negedge clk);
        reset = 1'b0;
        reset_model();
        idle_cycles(0, wait_of(0) + 2, seen);
        check("rst_mid_no_valid", seen, 1'b0);
        do_fetch(0, 8'h10, 1'b0, rom(8'h10), 1'b0, 8'h00);
        req_a[0] = 1'b0;

        // Latency at the WAIT_CYCLES extremes.
        do_fetch(1, 8'h22, 1'b0, rom(8'h22), 1'b0, 8'h00);
        do_fetch(1, 8'h22, 1'b1, rom(8'h22), 1'b0, 8'h00);
        do_fetch(1, 8'h23, 1'b0, rom(8'h23), 1'b0, 8'h00);
        req_a[1] = 1'b0;
        do_fetch(2, 8'h33, 1'b0, rom(8'h33), 1'b0, 8'h00);
        do_fetch(2, 8'h33, 1'b1, rom(8'h33), 1'b0, 8'h00);
        req_a[2] = 1'b0;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
